booth_r4_multiplier: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It is the next-generation replacement for the fixed 8-bit Booth unit in the ALU datapath. It adds configurable operand width, a per-operation signed/unsigned mode, and an explicit start/busy/done handshake. It retires two multiplier bits per cycle, so latency is fixed for a given width.

---
 rtl/booth_pkg.sv | 30 +++
 rtl/booth_r4_multiplier_if.sv | 30 +++
 rtl/booth_r4_recode.sv | 28 ++
 rtl/booth_r4_multiplier.sv | 98 +++++++++
 tb/tb_booth_r4_multiplier.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits
// and the triplet-to-digit recode rule.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic digit_t recode(input logic [2:0] triplet);
        case (triplet)
            3'b001, 3'b010: recode = POS1;
            3'b011:         recode = POS2;
            3'b100:         recode = NEG2;
            3'b101, 3'b110: recode = NEG1;
            default:        recode = ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Start/busy/done bus between a requester and the Booth multiplier,
// plus a debug view of the multiplier FSM state.
interface booth_r4_multiplier_if #(
    parameter int WIDTH = 8
);
    import booth_pkg::*;

    // en is a start request taken only while the unit is idle (busy=0); A, B and
    // signed_mode are captured on that same edge. busy stays high from the accepting
    // edge until the cycle after done; done pulses for one cycle as Output updates.
    logic               en;
    logic               signed_mode;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] Output;
    state_t             dbg_state;

    modport master (
        output en, signed_mode, A, B,
        input  busy, done, Output, dbg_state
    );

    modport slave (
        input  en, signed_mode, A, B,
        output busy, done, Output, dbg_state
    );

endinterface

// File: rtl/booth_r4_recode.sv
// Selects the radix-4 Booth partial product {0, +-M, +-2M} for one
// multiplier triplet, sign-extended to WE+1 bits.
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int WE = 10
) (
    input  logic [2:0]         triplet,
    input  logic signed [WE-1:0] m,
    output logic signed [WE:0]   pp
);

    digit_t             digit;
    logic signed [WE:0] m_ext;

    always_comb begin
        digit = recode(triplet);
        m_ext = {m[WE-1], m};
        case (digit)
            POS1:    pp = m_ext;
            POS2:    pp = m_ext <<< 1;
            NEG1:    pp = -m_ext;
            NEG2:    pp = -(m_ext <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier: two multiplier bits per cycle on
// WIDTH+2-bit extended operands, so signed and unsigned share one datapath.
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    booth_r4_multiplier_if.slave bus
);

    localparam int WE = WIDTH + 2;
    localparam int N  = WE / 2;
    localparam int CW = $clog2(N + 1);

    state_t                 state;
    logic                   busy_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     product;
    logic signed [WE-1:0]   m;
    logic [WE:0]            b_pad;
    logic [CW-1:0]          cnt;
    logic signed [2*WE:0]   acc;
    logic signed [2*WE:0]   acc_sum;
    logic signed [2*WE:0]   acc_next;
    logic signed [WE:0]     upper_sum;
    logic signed [WE:0]     pp;
    logic signed [WE-1:0]   a_ext;
    logic signed [WE-1:0]   b_ext;

    assign a_ext = bus.signed_mode ? {{2{bus.A[WIDTH-1]}}, bus.A} : {2'b00, bus.A};
    assign b_ext = bus.signed_mode ? {{2{bus.B[WIDTH-1]}}, bus.B} : {2'b00, bus.B};

    // b_pad carries the multiplier with the implicit b[-1]=0 appended; it is
    // shifted right two bits per step so the current triplet is always b_pad[2:0].
    booth_r4_recode #(.WE(WE)) u_recode (
        .triplet (b_pad[2:0]),
        .m       (m),
        .pp      (pp)
    );

    always_comb begin
        upper_sum = acc[2*WE:WE] + pp;
        acc_sum   = {upper_sum, acc[WE-1:0]};
        acc_next  = acc_sum >>> 2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            product <= '0;
            m       <= '0;
            b_pad   <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.en) begin
                        m      <= a_ext;
                        b_pad  <= {b_ext, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    b_pad <= {{2{b_pad[WE]}}, b_pad[WE:2]};
                    cnt   <= cnt + 1'b1;
                    // After N shifts of two the product sits at bit 0 of acc_next.
                    if (cnt == CW'(N - 1)) begin
                        product <= acc_next[2*WIDTH-1:0];
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.Output    = product;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Bench for booth_r4_multiplier at WIDTH=8 and WIDTH=16: an arithmetic
// reference model with a per-cycle compare process, plus directed literal cases.
module tb_booth_r4_multiplier;
    import booth_pkg::*;

    logic clk;
    logic rst_n;

    booth_r4_multiplier_if #(.WIDTH(8))  if8 ();
    booth_r4_multiplier_if #(.WIDTH(16)) if16 ();

    booth_r4_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    booth_r4_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input bit s);
        longint va, vb, p;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        p = va * vb;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    logic [31:0] exp8_q[$];
    int          due8_q[$];
    logic [31:0] exp16_q[$];
    int          due16_q[$];
    int          tick = 0;
    int          idle8 = 0;
    int          idle16 = 0;
    logic [31:0] out8_m = '0;
    logic [31:0] out16_m = '0;

    // A start is accepted on an edge where en=1 and the unit is free; the
    // result appears WIDTH/2+1 edges later and the unit is free again 2 edges after that.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp8_q.delete();  due8_q.delete();
            exp16_q.delete(); due16_q.delete();
            idle8 = 0; idle16 = 0;
            out8_m = '0; out16_m = '0;
        end else begin
            tick++;
            if (if8.en && tick >= idle8) begin
                exp8_q.push_back(ref_mul(8, {8'h00, if8.A}, {8'h00, if8.B}, if8.signed_mode));
                due8_q.push_back(tick + 5);
                idle8 = tick + 7;
            end
            if (if16.en && tick >= idle16) begin
                exp16_q.push_back(ref_mul(16, if16.A, if16.B, if16.signed_mode));
                due16_q.push_back(tick + 9);
                idle16 = tick + 11;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit exp_done;
        if (!rst_n) begin
            check("rst busy8", if8.busy, 0);
            check("rst done8", if8.done, 0);
            check("rst out8", if8.Output, 0);
            check("rst busy16", if16.busy, 0);
            check("rst done16", if16.done, 0);
            check("rst out16", if16.Output, 0);
        end else begin
            exp_done = (due8_q.size() > 0) && (due8_q[0] == tick);
            if (exp_done) begin
                out8_m = exp8_q.pop_front();
                void'(due8_q.pop_front());
            end
            check("done8", if8.done, exp_done);
            check("busy8", if8.busy, tick < idle8 - 1);
            check("out8", if8.Output, out8_m);

            exp_done = (due16_q.size() > 0) && (due16_q[0] == tick);
            if (exp_done) begin
                out16_m = exp16_q.pop_front();
                void'(due16_q.pop_front());
            end
            check("done16", if16.done, exp_done);
            check("busy16", if16.busy, tick < idle16 - 1);
            check("out16", if16.Output, out16_m);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input string name);
        int n;
        bit seen;
        @(negedge clk);
        if8.en = 1'b1; if8.A = a; if8.B = b; if8.signed_mode = s;
        @(negedge clk);
        if8.en = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (if8.done) seen = 1'b1;
        end
        check({name, " done seen"}, seen, 1);
        check({name, " latency"}, n, 5);
        check({name, " out"}, if8.Output, exp);
        @(negedge clk);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp, input string name);
        int n;
        bit seen;
        @(negedge clk);
        if16.en = 1'b1; if16.A = a; if16.B = b; if16.signed_mode = s;
        @(negedge clk);
        if16.en = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (if16.done) seen = 1'b1;
        end
        check({name, " done seen"}, seen, 1);
        check({name, " latency"}, n, 9);
        check({name, " out"}, if16.Output, exp);
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [15:0] v;
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 16'(32'd1 << (w - 1));
            2:       v = 16'((32'd1 << (w - 1)) - 1);
            3:       v = 16'hFFFF;
            default: v = 16'($urandom);
        endcase
        return v & mask;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int done_ticks[$];
        int held_n;
        logic [15:0] r;

        rst_n = 1'b0;
        if8.en = 1'b0;  if8.signed_mode = 1'b0;  if8.A = '0;  if8.B = '0;
        if16.en = 1'b0; if16.signed_mode = 1'b0; if16.A = '0; if16.B = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("reset busy", if8.busy, 0);
        check("reset done", if8.done, 0);
        check("reset out", if8.Output, 16'h0000);
        check("reset state", if8.dbg_state, IDLE);

        run8(8'h10, 8'hFE, 1'b1, 16'hFFE0, "s 10xFE");
        run8(8'h10, 8'hFE, 1'b0, 16'h0FE0, "u 10xFE");
        run8(8'h80, 8'h80, 1'b1, 16'h4000, "s 80x80");
        run8(8'h7F, 8'h80, 1'b1, 16'hC080, "s 7Fx80");
        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u FFxFF");
        run8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s FFxFF");
        run8(8'h5A, 8'h00, 1'b1, 16'h0000, "s 5Ax00");
        run8(8'h00, 8'hC3, 1'b0, 16'h0000, "u 00xC3");

        // en pulse and operand change while running must be ignored.
        @(negedge clk);
        if8.en = 1'b1; if8.A = 8'h23; if8.B = 8'h45; if8.signed_mode = 1'b0;
        @(negedge clk);
        if8.en = 1'b0;
        @(negedge clk);
        if8.en = 1'b1; if8.A = 8'hFF; if8.signed_mode = 1'b1;
        @(negedge clk);
        if8.en = 1'b0;
        repeat (3) @(negedge clk);
        check("ignore done", if8.done, 1);
        check("ignore out", if8.Output, 16'h096F);
        repeat (3) @(negedge clk);
        check("ignore no restart", if8.busy, 0);

        // Held en: back-to-back completions every 7 cycles.
        @(negedge clk);
        if8.en = 1'b1; if8.A = 8'h03; if8.B = 8'h05; if8.signed_mode = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (if8.done) done_ticks.push_back(tick);
        end
        if8.en = 1'b0;
        held_n = done_ticks.size();
        check("held count>=4", held_n >= 4, 1);
        for (int i = 1; i < held_n; i++)
            check("held period", done_ticks[i] - done_ticks[i-1], 7);
        check("held out", if8.Output, 16'h000F);
        repeat (10) @(negedge clk);

        // Reset two cycles after the start edge.
        if8.en = 1'b1; if8.A = 8'h33; if8.B = 8'h77; if8.signed_mode = 1'b1;
        @(negedge clk);
        if8.en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", if8.busy, 0);
        check("midrst out", if8.Output, 16'h0000);
        check("midrst state", if8.dbg_state, IDLE);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst no done", if8.Output, 16'h0000);
        run8(8'hF6, 8'h07, 1'b1, 16'hFFBA, "after rst");

        run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16 s min*min");
        run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 u max*max");

        // Random traffic on both widths, including en raised while busy.
        fork
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if8.en = ($urandom_range(0, 3) != 0);
                r = pick(8);
                if8.A = r[7:0];
                r = pick(8);
                if8.B = r[7:0];
                if8.signed_mode = $urandom_range(0, 1) == 1;
            end
            for (int j = 0; j < 300; j++) begin
                @(negedge clk);
                if16.en = ($urandom_range(0, 3) != 0);
                if16.A = pick(16);
                if16.B = pick(16);
                if16.signed_mode = $urandom_range(0, 1) == 1;
            end
        join
        @(negedge clk);
        if8.en = 1'b0;
        if16.en = 1'b0;
        repeat (15) @(negedge clk);
        check("drain8", exp8_q.size(), 0);
        check("drain16", exp16_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
